// File: rtl/negate_nbit_seq.sv
// Sequential two's-complement negator: inverts the operand, then ripples the +1 through 16-bit chunks, one chunk per cycle.
// Build option: define NEGATE_SATURATE_EN to clamp a most-negative operand to the most positive value instead of wrapping.
module negate_nbit_seq #(
  parameter int WIDTH = 48  // multiple of 16, at least 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);
  localparam int N  = WIDTH / 16;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CW-1:0]    k;
  logic             ovf;

  logic [WIDTH-1:0] work_nxt;
  logic             carry_nxt;
  logic [16:0]      sum;
  logic [WIDTH-1:0] result;

  // Add the pending carry into the chunk selected by k.
  always_comb begin
    work_nxt  = work;
    carry_nxt = carry;
    sum       = '0;
    for (int i = 0; i < N; i++) begin
      if (k == CW'(i)) begin
        sum                  = {1'b0, work[i*16 +: 16]} + {16'b0, carry};
        work_nxt[i*16 +: 16] = sum[15:0];
        carry_nxt            = sum[16];
      end
    end
  end

  always_comb begin
`ifdef NEGATE_SATURATE_EN
    result = ovf ? MOST_POS : work_nxt;
`else
    result = work_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      work      <= '0;
      carry     <= 1'b0;
      k         <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= ~in_data;
            carry    <= 1'b1;
            k        <= '0;
            ovf      <= (in_data == MOST_NEG);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= carry_nxt;
          // Carry out of the top chunk is dropped with the final result.
          if (k == LAST) begin
            k         <= '0;
            out_data  <= result;
            overflow  <= ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/negate_nbit_seq.md
NEGATE_NBIT_SEQ -- requirements
Module: negate_nbit_seq

Interface
REQ-001 Parameter WIDTH, default 48, operand and result width in bits; SHALL be a multiple of 16 and at least 16.
REQ-002 Parameter N (derived, not overridable) SHALL equal WIDTH/16, the number of 16-bit chunks.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  WIDTH  two's-complement operand.
REQ-008 out_valid  output  1  out_data and overflow are valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_data  output  WIDTH  two's-complement result, -in_data.
REQ-011 overflow  output  1  operand was the most negative value (1 followed by WIDTH-1 zeros).

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid=1, the block SHALL capture ~in_data into the work register, set carry=1, clear the chunk counter, latch the overflow condition, and enter RUN.
REQ-015 RUN: each cycle, chunk[k] SHALL be replaced by the low 16 bits of chunk[k]+carry (17-bit sum), carry SHALL take sum bit 16, and k SHALL increment, from k=0 (LSB chunk) to k=N-1.
REQ-016 RUN SHALL last exactly N cycles, then enter DONE; out_valid SHALL assert N rising edges after the accepting edge.
REQ-017 DONE: out_data and overflow SHALL hold stable until out_ready=1; on out_ready=1 the block SHALL return to IDLE on that edge.
REQ-018 While out_valid=0, out_ready SHALL be ignored; while in_ready=0, in_valid and in_data SHALL be ignored.
REQ-019 Final carry-out of chunk N-1 SHALL be discarded; -0 SHALL yield 0 with overflow=0.
REQ-020 overflow SHALL be 1 if and only if the accepted operand was the most negative value.
REQ-021 Throughput SHALL be one operand per N+2 cycles when out_ready is held high: accept edge, N RUN edges, one DONE edge.

Reset
REQ-022 reset=1 SHALL force IDLE on the next edge, from any state, including mid-RUN and mid-DONE; an in-flight operand SHALL be dropped.
REQ-023 Reset values SHALL be: in_ready=1 once reset deasserts, out_valid=0, out_data=0, overflow=0, carry=0, chunk counter=0.
REQ-024 reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro NEGATE_SATURATE_EN SHALL select the overflow result.
REQ-026 With NEGATE_SATURATE_EN defined, a most-negative operand SHALL produce the most positive value (0 followed by WIDTH-1 ones), with overflow=1.
REQ-027 Without NEGATE_SATURATE_EN, a most-negative operand SHALL produce the wrapped result (equal to the operand), with overflow=1.
REQ-028 All other operands SHALL give identical results with or without the macro.

Verification (WIDTH=48, N=3)
REQ-029 in_data=0x000000000001 -> out_data=0xFFFFFFFFFFFF, overflow=0, out_valid high exactly 3 edges after acceptance.
REQ-030 in_data=0x000000010000 -> out_data=0xFFFFFFFF0000, which checks inter-chunk carry; in_data=0x000000000000 -> out_data=0x000000000000, overflow=0.
REQ-031 in_data=0x800000000000 -> overflow=1 and out_data=0x7FFFFFFFFFFF with NEGATE_SATURATE_EN, or 0x800000000000 without it.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, a new in_valid is ignored; then out_ready=1 -> IDLE next edge.
REQ-033 Assert reset on the second RUN cycle -> IDLE next edge, out_valid=0, out_data=0; a fresh operand 0x000000000005 then yields 0xFFFFFFFFFFFB.
REQ-034 Apply 4 back-to-back operands with out_ready=1 -> each accepted exactly 5 cycles apart, with results in order.
